// File: rtl/control_alineacion_bc.sv
// +----------------------------------------------------------------------------+
// | Module  : control_alineacion_bc                                            |
// | Brief   : Serial 0xBC comma alignment, lock acquisition and byte delivery. |
// | Rev     : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module control_alineacion_bc #(
    parameter int BC_LOCK  = 4,
    parameter int MAX_NOBC = 16
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       data_input,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       byte_strobe,
    output logic       active_out,
    output logic [2:0] BC_counter
);

    localparam logic [7:0] c_bc       = 8'hBC;
    localparam logic [2:0] c_bc_lock  = 3'(BC_LOCK);
    localparam logic [7:0] c_max_nobc = 8'(MAX_NOBC);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        LOCK   = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [6:0] r_sr;
    logic [2:0] r_bit_cnt, w_bit_cnt_nxt;
    logic [7:0] r_nobc_cnt, w_nobc_cnt_nxt;
    logic [2:0] r_bc_cnt, w_bc_cnt_nxt;
    logic [7:0] r_data, w_data_nxt;
    logic       r_valid, w_valid_nxt;
    logic       r_strobe, w_strobe_nxt;

    logic [7:0] w_window;
    logic       w_boundary;
    logic       w_is_bc;
    logic [2:0] w_bc_inc;
    logic [7:0] w_nobc_inc;

    // The window always includes the bit being sampled, so a symbol is seen
    // on the very edge that captures its last bit.
    assign w_window   = {r_sr, data_input};
    assign w_boundary = (r_bit_cnt == 3'd7);
    assign w_is_bc    = (w_window == c_bc);
    assign w_bc_inc   = r_bc_cnt + 3'd1;
    assign w_nobc_inc = r_nobc_cnt + 8'd1;

    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            r_state    <= HUNT;
            r_sr       <= 7'd0;
            r_bit_cnt  <= 3'd0;
            r_nobc_cnt <= 8'd0;
            r_bc_cnt   <= 3'd0;
            r_data     <= 8'h00;
            r_valid    <= 1'b0;
            r_strobe   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_sr       <= w_window[6:0];
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_nobc_cnt <= w_nobc_cnt_nxt;
            r_bc_cnt   <= w_bc_cnt_nxt;
            r_data     <= w_data_nxt;
            r_valid    <= w_valid_nxt;
            r_strobe   <= w_strobe_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_bit_cnt_nxt  = r_bit_cnt + 3'd1;
        w_nobc_cnt_nxt = r_nobc_cnt;
        w_bc_cnt_nxt   = r_bc_cnt;
        w_data_nxt     = r_data;
        w_valid_nxt    = r_valid;
        w_strobe_nxt   = 1'b0;

        unique case (r_state)
            HUNT: begin
                w_valid_nxt   = 1'b0;
                w_bit_cnt_nxt = 3'd0;
                if (w_is_bc) begin
                    w_bc_cnt_nxt = 3'd1;
                    if (c_bc_lock == 3'd1) begin
                        w_state_nxt    = ACTIVE;
                        w_nobc_cnt_nxt = 8'd0;
                    end else begin
                        w_state_nxt = LOCK;
                    end
                end
            end

            LOCK: begin
                w_valid_nxt = 1'b0;
                if (w_boundary) begin
                    if (w_is_bc) begin
                        w_bc_cnt_nxt = w_bc_inc;
                        if (w_bc_inc == c_bc_lock) begin
                            w_state_nxt    = ACTIVE;
                            w_nobc_cnt_nxt = 8'd0;
                        end
                    end else begin
                        // A broken BC run drops straight back; this window
                        // is not reconsidered as a new candidate.
                        w_state_nxt  = HUNT;
                        w_bc_cnt_nxt = 3'd0;
                    end
                end
            end

            ACTIVE: begin
                if (w_boundary) begin
                    if (w_is_bc) begin
                        w_data_nxt     = c_bc;
                        w_valid_nxt    = 1'b0;
                        w_strobe_nxt   = 1'b1;
                        w_nobc_cnt_nxt = 8'd0;
                    end else if (w_nobc_inc < c_max_nobc) begin
                        w_data_nxt     = w_window;
                        w_valid_nxt    = 1'b1;
                        w_strobe_nxt   = 1'b1;
                        w_nobc_cnt_nxt = w_nobc_inc;
                    end else begin
                        // Too long without a comma: discard and re-hunt.
                        w_valid_nxt    = 1'b0;
                        w_state_nxt    = HUNT;
                        w_bc_cnt_nxt   = 3'd0;
                        w_nobc_cnt_nxt = 8'd0;
                    end
                end
            end

            default: begin
                w_state_nxt   = HUNT;
                w_bit_cnt_nxt = 3'd0;
            end
        endcase
    end

    assign data_out    = r_data;
    assign valid_out   = r_valid;
    assign byte_strobe = r_strobe;
    assign active_out  = (r_state == ACTIVE);
    assign BC_counter  = r_bc_cnt;

endmodule

`default_nettype wire

// File: tb/tb_control_alineacion_bc.sv
// +----------------------------------------------------------------------------+
// | Module  : tb_control_alineacion_bc                                         |
// | Brief   : Scoreboard bench for the BC alignment controller.                |
// | Rev     : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_control_alineacion_bc;

    logic       clk_32f;
    logic       reset;
    logic       data_input;
    logic [7:0] data_out;
    logic       valid_out;
    logic       byte_strobe;
    logic       active_out;
    logic [2:0] BC_counter;

    int n_total;
    int n_pass;

    // Expected deliveries: {valid, data}
    logic [8:0] sb_q[$];

    control_alineacion_bc #(
        .BC_LOCK (4),
        .MAX_NOBC(16)
    ) dut (
        .clk_32f    (clk_32f),
        .reset      (reset),
        .data_input (data_input),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .byte_strobe(byte_strobe),
        .active_out (active_out),
        .BC_counter (BC_counter)
    );

    initial clk_32f = 1'b0;
    always #5 clk_32f = ~clk_32f;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic send_bit(input logic b);
        data_input = b;
        @(posedge clk_32f);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    // Monitor: every strobe must match the oldest expected delivery.
    always @(negedge clk_32f) begin
        if (!reset && byte_strobe) begin
            if (sb_q.size() == 0) begin
                check("unexpected_strobe", {24'd0, data_out}, 32'hFFFF_FFFF);
            end else begin
                logic [8:0] e;
                e = sb_q.pop_front();
                check("sb_data", {24'd0, data_out}, {24'd0, e[7:0]});
                check("sb_valid", {31'd0, valid_out}, {31'd0, e[8]});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] bc;
        logic [7:0] p;
        bc = 8'hBC;
        n_total = 0;
        n_pass  = 0;
        data_input = 1'b0;
        reset = 1'b1;
        #1;
        check("rst_data", {24'd0, data_out}, 32'h00);
        check("rst_valid", {31'd0, valid_out}, 32'd0);
        check("rst_strobe", {31'd0, byte_strobe}, 32'd0);
        check("rst_active", {31'd0, active_out}, 32'd0);
        check("rst_bccnt", {29'd0, BC_counter}, 32'd0);
        @(posedge clk_32f);
        @(posedge clk_32f);
        #1;
        reset = 1'b0;

        // Lock on four BCs after three zero bits, then first payload.
        for (int i = 0; i < 3; i++) send_bit(1'b0);
        for (int k = 1; k <= 3; k++) begin
            send_byte(bc);
            check("lock_bccnt", {29'd0, BC_counter}, k);
            check("lock_active", {31'd0, active_out}, 32'd0);
        end
        send_byte(bc);
        check("act_rise", {31'd0, active_out}, 32'd1);
        check("act_bccnt", {29'd0, BC_counter}, 32'd4);
        check("act_strobe", {31'd0, byte_strobe}, 32'd0);
        sb_q.push_back({1'b1, 8'hA5});
        send_byte(8'hA5);
        check("a5_data", {24'd0, data_out}, 32'hA5);
        check("a5_valid", {31'd0, valid_out}, 32'd1);
        check("a5_strobe", {31'd0, byte_strobe}, 32'd1);

        // BC then sixteen payload symbols: the sixteenth forces loss of sync.
        sb_q.push_back({1'b0, 8'hBC});
        send_bit(bc[7]);
        check("a5_strobe_1cyc", {31'd0, byte_strobe}, 32'd0);
        check("a5_hold", {23'd0, valid_out, data_out}, {23'd0, 1'b1, 8'hA5});
        for (int i = 6; i >= 0; i--) send_bit(bc[i]);
        check("bc_valid", {31'd0, valid_out}, 32'd0);
        check("bc_data", {24'd0, data_out}, 32'hBC);
        for (int n = 1; n <= 15; n++) begin
            p = 8'(n);
            sb_q.push_back({1'b1, p});
            send_byte(p);
        end
        check("pre_drop_active", {31'd0, active_out}, 32'd1);
        send_byte(8'h10);
        check("drop_active", {31'd0, active_out}, 32'd0);
        check("drop_valid", {31'd0, valid_out}, 32'd0);
        check("drop_strobe", {31'd0, byte_strobe}, 32'd0);
        check("drop_data", {24'd0, data_out}, 32'h0F);
        check("drop_bccnt", {29'd0, BC_counter}, 32'd0);

        // Three BCs then a non-BC: lock attempt aborts.
        send_byte(8'h00);
        for (int k = 1; k <= 3; k++) begin
            send_byte(bc);
            check("abort_bccnt", {29'd0, BC_counter}, k);
        end
        send_byte(8'h12);
        check("abort_bccnt_clr", {29'd0, BC_counter}, 32'd0);
        check("abort_active", {31'd0, active_out}, 32'd0);
        check("abort_valid", {31'd0, valid_out}, 32'd0);

        // Leading junk without a BC window; lock must align on the first BC.
        reset = 1'b1;
        @(posedge clk_32f);
        #1;
        reset = 1'b0;
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        send_byte(bc);
        check("junk_bccnt", {29'd0, BC_counter}, 32'd1);
        for (int k = 0; k < 3; k++) send_byte(bc);
        check("junk_active", {31'd0, active_out}, 32'd1);
        sb_q.push_back({1'b1, 8'h3C});
        send_byte(8'h3C);
        check("3c_data", {24'd0, data_out}, 32'h3C);
        check("3c_valid", {31'd0, valid_out}, 32'd1);

        // Asynchronous reset mid-symbol while delivering payload.
        sb_q.push_back({1'b1, 8'hA5});
        send_byte(8'hA5);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        #2;
        reset = 1'b1;
        #1;
        check("arst_data", {24'd0, data_out}, 32'h00);
        check("arst_valid", {31'd0, valid_out}, 32'd0);
        check("arst_active", {31'd0, active_out}, 32'd0);
        check("arst_bccnt", {29'd0, BC_counter}, 32'd0);
        check("arst_strobe", {31'd0, byte_strobe}, 32'd0);
        @(posedge clk_32f);
        #1;
        reset = 1'b0;
        for (int k = 0; k < 4; k++) send_byte(bc);
        check("relock_active", {31'd0, active_out}, 32'd1);
        check("relock_bccnt", {29'd0, BC_counter}, 32'd4);
        sb_q.push_back({1'b1, 8'h5A});
        send_byte(8'h5A);
        send_bit(1'b0);
        check("sb_empty", sb_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/control_alineacion_bc.md
CONTROL_ALINEACION_BC -- requirements
Module: control_alineacion_bc

Interface
REQ-001 The block SHALL have parameter BC_LOCK, default 4, number of consecutive aligned 0xBC symbols needed to go active (legal 1..7).
REQ-002 The block SHALL have parameter MAX_NOBC, default 16, number of consecutive non-BC symbols in ACTIVE that forces loss of sync (legal 2..255).
REQ-003 The block SHALL have port clk_32f, input, 1 bit: bit-rate clock, the only clock; all logic on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port data_input, input, 1 bit: serial stream, one bit per clk_32f, MSB of each symbol first.
REQ-006 The block SHALL have port data_out, output, 8 bits: last delivered symbol, registered.
REQ-007 The block SHALL have port valid_out, output, 1 bit: data_out holds a payload (non-BC) symbol.
REQ-008 The block SHALL have port byte_strobe, output, 1 bit: one-cycle pulse when data_out/valid_out update.
REQ-009 The block SHALL have port active_out, output, 1 bit: high exactly while in state ACTIVE.
REQ-010 The block SHALL have port BC_counter, output, 3 bits: aligned BC symbols counted during lock acquisition.

Function
REQ-011 The block SHALL form window w = {sr[6:0], data_input} every cycle and SHALL shift sr <= w on every edge.
REQ-012 The block SHALL implement states HUNT, LOCK and ACTIVE, with a 3-bit bit_cnt and an 8-bit nobc_cnt.
REQ-013 In HUNT, on an edge where w == 8'hBC, the block SHALL set bit_cnt = 0 and BC_counter = 1, and SHALL go to LOCK (or to ACTIVE if BC_LOCK == 1); otherwise it SHALL stay in HUNT.
REQ-014 In LOCK and ACTIVE, bit_cnt SHALL increment every edge and wrap 7 -> 0; a symbol boundary is the edge where bit_cnt == 7, and w on that edge is the symbol.
REQ-015 In LOCK, at a boundary with w == 8'hBC, BC_counter SHALL increment; when the incremented value equals BC_LOCK the block SHALL go to ACTIVE and clear nobc_cnt.
REQ-016 In LOCK, at a boundary with w != 8'hBC, the block SHALL return to HUNT and clear BC_counter to 0; that window SHALL NOT be re-evaluated as a BC candidate.
REQ-017 In HUNT and LOCK, valid_out and byte_strobe SHALL be 0, and data_out SHALL hold its value.
REQ-018 In ACTIVE, a boundary with w == 8'hBC SHALL load data_out = 8'hBC, set valid_out = 0, pulse byte_strobe and clear nobc_cnt.
REQ-019 In ACTIVE, a boundary with w != 8'hBC SHALL increment nobc_cnt. If the new value is below MAX_NOBC, it SHALL load data_out = w, set valid_out = 1 and pulse byte_strobe.
REQ-020 If the new nobc_cnt value equals MAX_NOBC, the symbol SHALL be discarded: valid_out = 0, no strobe, data_out held. The block SHALL go to HUNT and clear BC_counter and nobc_cnt.
REQ-021 Outputs SHALL update on the same edge that samples the symbol's last bit, giving zero extra latency. valid_out and data_out SHALL hold between boundaries.
REQ-022 byte_strobe SHALL be high only for the single cycle after a boundary edge in ACTIVE.
REQ-023 active_out SHALL change on the same edge as the state transition.
REQ-024 BC_counter SHALL hold BC_LOCK while in ACTIVE.

Reset
REQ-025 While reset is high, the block SHALL force: state HUNT, sr = 0, bit_cnt = 0, nobc_cnt = 0, BC_counter = 0, data_out = 8'h00, valid_out = 0, byte_strobe = 0, active_out = 0.
REQ-026 Reset asserted in any state, mid-symbol, SHALL take effect immediately without waiting for a clock edge.
REQ-027 After reset release, the first edge SHALL already shift data_input into sr, and detection SHALL restart in HUNT.

Verification
REQ-028 Stimulus: 3 zero bits, 4x 0xBC, then 0xA5, with default parameters. Required: active_out rises on the last bit of the 4th BC with BC_counter = 4; on the last bit of 0xA5, data_out = A5, valid_out = 1 and byte_strobe = 1 for 1 cycle.
REQ-029 Stimulus: 3x 0xBC then 0x12. Required: BC_counter goes 1, 2, 3, then 0 at the 0x12 boundary; state returns to HUNT; active_out, valid_out and byte_strobe stay 0 throughout.
REQ-030 Stimulus: 5 arbitrary bits containing no BC window, then 4x 0xBC and 0x3C. Required: lock aligns to the first BC; 0x3C is delivered with valid_out = 1.
REQ-031 Stimulus: in ACTIVE, 0xBC then 16 consecutive non-BC symbols. Required: the BC gives data_out = BC with valid_out = 0; symbols 1-15 are delivered with valid_out = 1; on the 16th, there is no strobe, valid_out = 0 and active_out falls.
REQ-032 Stimulus: reset pulsed mid-symbol while ACTIVE with data_out = A5, valid_out = 1. Required: all outputs are 0 immediately; after release, 4x 0xBC re-acquire the lock.
